// File: rtl/xsw_rr_arb_mux_if.sv
// Valid/ready bundle between N_PORTS upstream streams, the arbitrating mux and the output slice.
// master = environment side (drives requests and output ready), slave = the arbiter.
interface xsw_rr_arb_mux_if #(
    parameter int N_PORTS = 4,
    parameter int D_WIDTH = 16
);
    localparam int PTR_W = $clog2(N_PORTS);

    logic [N_PORTS-1:0]         vldi;
    logic [N_PORTS-1:0]         rdyi;
    logic [N_PORTS*D_WIDTH-1:0] datai;
    logic [N_PORTS-1:0]         lasti;
    logic                       vldo;
    logic                       rdyo;
    logic [D_WIDTH-1:0]         datao;
    logic                       lasto;
    logic [PTR_W-1:0]           grant_idx;

    modport master (
        output vldi, datai, lasti, rdyo,
        input  rdyi, vldo, datao, lasto, grant_idx
    );

    modport slave (
        input  vldi, datai, lasti, rdyo,
        output rdyi, vldo, datao, lasto, grant_idx
    );
endinterface

// File: rtl/xsw_rr_arb_mux.sv
// N:1 round-robin arbitrating mux with zero-latency datapath and stall-hold of the grant.
// Optional packet lock (no interleaving of packets) is enabled by defining XSW_ARB_PKT_LOCK_EN.
module xsw_rr_arb_mux #(
    parameter int N_PORTS = 4,
    parameter int D_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rstn,
    xsw_rr_arb_mux_if.slave bus
);
    localparam int PTR_W = $clog2(N_PORTS);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_HELD,
        ST_LOCKED
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   owner_nxt;
    logic [PTR_W-1:0]   rr_win;
    logic [PTR_W-1:0]   grant;
    logic               sel_vld;
    logic               sel_last;
    logic [D_WIDTH-1:0] sel_data;
    logic               xfer;
    logic               stall;

    // Modular add that also works when N_PORTS is not a power of two.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_PORTS) begin
            s = s - N_PORTS;
        end
        return PTR_W'(s);
    endfunction

    // Scanning from the farthest candidate back to ptr leaves the nearest requester as winner.
    always_comb begin
        rr_win = ptr;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (bus.vldi[wrap_inc(ptr, k)]) begin
                rr_win = wrap_inc(ptr, k);
            end
        end
    end

    assign grant = (state == ST_FREE) ? rr_win : owner;

    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant == PTR_W'(i)) begin
                sel_vld  = bus.vldi[i];
                sel_last = bus.lasti[i];
                sel_data = bus.datai[i*D_WIDTH +: D_WIDTH];
            end
        end
    end

    // Reset gates valid/ready so no handshake can complete while rstn is low.
    always_comb begin
        bus.rdyi = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            bus.rdyi[i] = rstn && bus.rdyo && (grant == PTR_W'(i));
        end
    end

    assign bus.vldo      = rstn & sel_vld;
    assign bus.datao     = sel_data;
    assign bus.lasto     = sel_last;
    assign bus.grant_idx = grant;

    assign xfer  = bus.vldo & bus.rdyo;
    assign stall = bus.vldo & ~bus.rdyo;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        if (xfer) begin
`ifdef XSW_ARB_PKT_LOCK_EN
            if (!sel_last) begin
                state_nxt = ST_LOCKED;
                owner_nxt = grant;
            end else begin
                state_nxt = ST_FREE;
                ptr_nxt   = wrap_inc(grant, 1);
            end
`else
            state_nxt = ST_FREE;
            ptr_nxt   = wrap_inc(grant, 1);
`endif
        end else if (stall) begin
            state_nxt = ST_HELD;
            owner_nxt = grant;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_FREE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

`ifndef SYNTHESIS
    stall_stable_a: assert property (@(posedge clk) disable iff (!rstn)
        (bus.vldo && !bus.rdyo) |=> (bus.datao == $past(bus.datao) && bus.grant_idx == $past(bus.grant_idx)));

    rdyi_onehot_a: assert property (@(posedge clk) $onehot0(bus.rdyi));
`endif
endmodule
